// File: rtl/fnd_pkg.sv
// Shared types and constants for the FND multiplex scan path: state enum,
// digit geometry and the active-low gfedcba glyph table for hex nibbles.
package fnd_pkg;

  localparam int FND_NUM_DIGITS = 4;
  localparam int FND_SEL_W      = 2;
  localparam int FND_BCD_W      = 4 * FND_NUM_DIGITS;

  localparam logic [6:0] FND_FONT_BLANK = 7'h7F;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BLANK = 2'd1,
    DRIVE = 2'd2
  } fnd_state_e;

  // Entry 0 is the rightmost element: glyphs for 0..F, gfedcba, active-low
  localparam logic [15:0][6:0] FND_FONT_TBL = {
    7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
    7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
  };

  function automatic logic [6:0] font7(input logic [3:0] nib);
    return FND_FONT_TBL[nib];
  endfunction

endpackage

// File: rtl/fnd_scan_controller_if.sv
// Display-side bundle of the scan controller: frame data in, digit/segment
// drive and frame marker out. master = data source / observer, slave = controller.
interface fnd_scan_controller_if;
  import fnd_pkg::*;

  logic [FND_BCD_W-1:0]      i_bcd;
  logic [FND_NUM_DIGITS-1:0] i_dp;
  logic [FND_NUM_DIGITS-1:0] o_fnd_com;
  logic [7:0]                o_fnd_font;
  logic [FND_SEL_W-1:0]      o_digit_sel;
  logic                      o_frame_done;

  modport master (
    output i_bcd, i_dp,
    input  o_fnd_com, o_fnd_font, o_digit_sel, o_frame_done
  );

  modport slave (
    input  i_bcd, i_dp,
    output o_fnd_com, o_fnd_font, o_digit_sel, o_frame_done
  );

endinterface

// File: rtl/fnd_font_decoder.sv
// Combinational hex nibble to 7-segment glyph (gfedcba, active-low).
module fnd_font_decoder
  import fnd_pkg::*;
(
  input  logic [3:0] nib_i,
  output logic [6:0] seg_o
);

  assign seg_o = font7(nib_i);

endmodule

// File: rtl/fnd_scan_controller.sv
// 4-digit common-anode multiplex scan stepped by the synchronised FND clock,
// with per-digit dead-time and once-per-frame latching. Optional: FND_LEADING_ZERO_BLANK_EN.
module fnd_scan_controller
  import fnd_pkg::*;
#(
  parameter int NUM_DIGITS   = FND_NUM_DIGITS,
  parameter int BLANK_CYCLES = 200,
  parameter int CNT_W        = 8
) (
  input  logic                  i_clk,
  input  logic                  i_reset_n,
  input  logic                  i_fnd_clk,
  fnd_scan_controller_if.slave  bus
);

  localparam int SEL_W = $clog2(NUM_DIGITS);
  // BLANK_CYCLES==0 still spends one cycle in BLANK: cnt 0 matches immediately
  localparam logic [CNT_W-1:0] CNT_LAST = (BLANK_CYCLES == 0) ? '0 : CNT_W'(BLANK_CYCLES - 1);
  localparam logic [SEL_W-1:0] SEL_LAST = SEL_W'(NUM_DIGITS - 1);

  logic fnd_meta_q, fnd_sync_q, fnd_edge_q;
  logic tick, wrap;

  fnd_state_e                 state_q, state_d;
  logic [CNT_W-1:0]           cnt_q, cnt_d;
  logic [SEL_W-1:0]           sel_q, sel_d;
  logic [NUM_DIGITS-1:0][3:0] frame_bcd_q;
  logic [NUM_DIGITS-1:0]      frame_dp_q;
  logic                       frame_done_q;
  logic [NUM_DIGITS-1:0]      com_q, com_d;
  logic [7:0]                 font_q, font_d;

  logic [3:0] nib;
  logic [6:0] seg_raw, seg;

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      fnd_meta_q <= 1'b0;
      fnd_sync_q <= 1'b0;
      fnd_edge_q <= 1'b0;
    end else begin
      fnd_meta_q <= i_fnd_clk;
      fnd_sync_q <= fnd_meta_q;
      fnd_edge_q <= fnd_sync_q;
    end
  end

  assign tick = fnd_sync_q & ~fnd_edge_q;
  assign wrap = tick && (sel_q == SEL_LAST);

  // A tick always restarts the dead-time, whatever the current state
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sel_d   = sel_q;
    if (tick) begin
      state_d = BLANK;
      cnt_d   = '0;
      sel_d   = sel_q + SEL_W'(1);
    end else begin
      case (state_q)
        BLANK: begin
          if (cnt_q == CNT_LAST) state_d = DRIVE;
          else                   cnt_d   = cnt_q + CNT_W'(1);
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      sel_q        <= '0;
      frame_bcd_q  <= '0;
      frame_dp_q   <= '0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      sel_q        <= sel_d;
      frame_done_q <= wrap;
      if (wrap) begin
        frame_bcd_q <= bus.i_bcd;
        frame_dp_q  <= bus.i_dp;
      end
    end
  end

  assign nib = frame_bcd_q[sel_q];

  fnd_font_decoder u_font (
    .nib_i (nib),
    .seg_o (seg_raw)
  );

`ifdef FND_LEADING_ZERO_BLANK_EN
  logic [NUM_DIGITS-1:0] lz;
  logic                  upper_zero;

  // lz[k]: digit k and every digit above it are zero; digit 0 is never blanked
  always_comb begin
    lz         = '0;
    upper_zero = 1'b1;
    for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
      upper_zero = upper_zero & (frame_bcd_q[k] == 4'h0);
      lz[k]      = upper_zero;
    end
  end

  assign seg = lz[sel_q] ? FND_FONT_BLANK : seg_raw;
`else
  assign seg = seg_raw;
`endif

  always_comb begin
    com_d  = '1;
    font_d = '1;
    if (state_q == DRIVE) begin
      com_d  = ~(NUM_DIGITS'(1) << sel_q);
      font_d = {~frame_dp_q[sel_q], seg};
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      com_q  <= '1;
      font_q <= '1;
    end else begin
      com_q  <= com_d;
      font_q <= font_d;
    end
  end

  assign bus.o_fnd_com    = com_q;
  assign bus.o_fnd_font   = font_q;
  assign bus.o_digit_sel  = sel_q;
  assign bus.o_frame_done = frame_done_q;

endmodule

// File: tb/tb_fnd_scan_controller.sv
// Bench for fnd_scan_controller: spec vector table, randomized frames against a
// tick-level display model, and hand sequences for reset, freeze and tick storms.
module tb_fnd_scan_controller;

  localparam int BC = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic fnd_clk = 1'b0;

  always #5 clk = ~clk;

  fnd_scan_controller_if bus ();
  fnd_scan_controller_if bus0 ();

  fnd_scan_controller #(.BLANK_CYCLES(BC), .CNT_W(8)) dut (
    .i_clk     (clk),
    .i_reset_n (rst_n),
    .i_fnd_clk (fnd_clk),
    .bus       (bus)
  );

  fnd_scan_controller #(.BLANK_CYCLES(0), .CNT_W(8)) dut0 (
    .i_clk     (clk),
    .i_reset_n (rst_n),
    .i_fnd_clk (fnd_clk),
    .bus       (bus0)
  );

  typedef struct {
    logic [15:0]     bcd;
    logic [3:0]      dp;
    logic [3:0][7:0] font;   // expected glyph per digit, index = digit
  } vec_t;

  vec_t       tbl [4];
  logic [7:0] glyph [16];

  int n_cmp = 0;
  int n_bad = 0;

  // display model: which digit is up and what frame it shows
  int          m_sel;
  logic [15:0] m_bcd;
  logic [3:0]  m_dp;
  logic        m_wrap;
  logic [15:0] cur_bcd;
  logic [3:0]  cur_dp;
  logic [3:0]  last_com;
  logic [7:0]  last_font;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] exp_font(input int sel, input logic [15:0] bcd, input logic [3:0] dp);
    int         nib;
    logic [7:0] g;
    logic [6:0] seg;
    nib = int'((bcd >> (4 * sel)) & 16'h000F);
    g   = glyph[nib];
    seg = g[6:0];
`ifdef FND_LEADING_ZERO_BLANK_EN
    if (sel > 0 && (bcd >> (4 * sel)) == 16'h0) seg = 7'h7F;
`endif
    return {~dp[sel], seg};
  endfunction

  function automatic logic [3:0] exp_com(input int sel);
    return 4'hF ^ (4'b0001 << sel);
  endfunction

  task automatic set_in(input logic [15:0] bcd, input logic [3:0] dp);
    cur_bcd   = bcd;
    cur_dp    = dp;
    bus.i_bcd = bcd;
    bus.i_dp  = dp;
    bus0.i_bcd = bcd;
    bus0.i_dp  = dp;
  endtask

  task automatic model_tick();
    m_sel  = (m_sel + 1) % 4;
    m_wrap = (m_sel == 0);
    if (m_wrap) begin
      m_bcd = cur_bcd;
      m_dp  = cur_dp;
    end
  endtask

  // One FND clock period of T system cycles; rise is applied just after an edge
  task automatic run_period(input int T);
    int fd_cnt;
    fd_cnt  = 0;
    fnd_clk = 1'b1;
    model_tick();
    for (int c = 1; c <= T; c++) begin
      @(posedge clk); #1;
      if (c == T / 2) fnd_clk = 1'b0;
      if (bus.o_frame_done) fd_cnt++;
      if (c == 3) begin
        chk("digit_sel", 32'(bus.o_digit_sel), m_sel);
        chk("frame_done_at_tick", 32'(bus.o_frame_done), m_wrap ? 1 : 0);
      end
      if (c == 3 + BC) chk("last_blank_com", 32'(bus.o_fnd_com), 32'hF);
      if (c == 4 + BC) begin
        chk("first_drive_com", 32'(bus.o_fnd_com), 32'(exp_com(m_sel)));
        chk("first_drive_font", 32'(bus.o_fnd_font), 32'(exp_font(m_sel, m_bcd, m_dp)));
      end
      if (c == 4) chk("bc0_blank_com", 32'(bus0.o_fnd_com), 32'hF);
      if (c == 5) begin
        chk("bc0_drive_com", 32'(bus0.o_fnd_com), 32'(exp_com(m_sel)));
        chk("bc0_drive_font", 32'(bus0.o_fnd_font), 32'(exp_font(m_sel, m_bcd, m_dp)));
      end
    end
    chk("frame_done_count", fd_cnt, m_wrap ? 1 : 0);
    chk("hold_com", 32'(bus.o_fnd_com), 32'(exp_com(m_sel)));
    chk("hold_font", 32'(bus.o_fnd_font), 32'(exp_font(m_sel, m_bcd, m_dp)));
    last_com  = bus.o_fnd_com;
    last_font = bus.o_fnd_font;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int nonf, changes;

    glyph = '{8'h40, 8'h79, 8'h24, 8'h30, 8'h19, 8'h12, 8'h02, 8'h78,
              8'h00, 8'h10, 8'h08, 8'h03, 8'h46, 8'h21, 8'h06, 8'h0E};
    tbl[0] = '{16'h1234, 4'b0000, {8'hF9, 8'hA4, 8'hB0, 8'h99}};
    tbl[1] = '{16'hABCD, 4'b0000, {8'h88, 8'h83, 8'hC6, 8'hA1}};
    tbl[2] = '{16'hF00E, 4'b0001, {8'h8E, 8'hC0, 8'hC0, 8'h06}};
`ifdef FND_LEADING_ZERO_BLANK_EN
    tbl[3] = '{16'h0070, 4'b0000, {8'hFF, 8'hFF, 8'hF8, 8'hC0}};
`else
    tbl[3] = '{16'h0070, 4'b0000, {8'hC0, 8'hC0, 8'hF8, 8'hC0}};
`endif

    set_in(16'h0, 4'h0);
    m_sel = 0; m_bcd = 16'h0; m_dp = 4'h0; m_wrap = 1'b0;

    // reset held: FND clock activity must not move anything
    for (int i = 0; i < 6; i++) begin
      fnd_clk = ~fnd_clk;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_com", 32'(bus.o_fnd_com), 32'hF);
      chk("rst_font", 32'(bus.o_fnd_font), 32'hFF);
      chk("rst_sel", 32'(bus.o_digit_sel), 0);
      chk("rst_frame_done", 32'(bus.o_frame_done), 0);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    chk("idle_com", 32'(bus.o_fnd_com), 32'hF);
    chk("idle_font", 32'(bus.o_fnd_font), 32'hFF);
    chk("idle_sel", 32'(bus.o_digit_sel), 0);

    while (m_sel != 3) run_period(16);

    // spec vectors; 1234 -> ABCD change lands while digit 2 is up
    for (int v = 0; v < 4; v++) begin
      set_in(tbl[v].bcd, tbl[v].dp);
      for (int d = 0; d < 4; d++) begin
        if (v == 0 && d == 3) set_in(tbl[1].bcd, tbl[1].dp);
        run_period(20);
        chk($sformatf("tbl%0d_d%0d_com", v, d), 32'(last_com), 32'(4'hF ^ (4'b0001 << d)));
        chk($sformatf("tbl%0d_d%0d_font", v, d), 32'(last_font), 32'(tbl[v].font[d]));
      end
    end

    repeat (40) begin
      if ($urandom_range(0, 2) == 0) set_in(16'($urandom), 4'($urandom));
      run_period(int'($urandom_range(12, 30)));
    end

    // frozen FND clock: current digit stays lit
    changes = 0;
    repeat (60) begin
      @(posedge clk); #1;
      if (bus.o_fnd_com !== last_com || bus.o_fnd_font !== last_font) changes++;
    end
    chk("freeze_changes", changes, 0);
    chk("freeze_sel", 32'(bus.o_digit_sel), m_sel);

    // ticks faster than the dead-time: never reaches DRIVE, digits keep stepping
    nonf = 0;
    for (int p = 0; p < 10; p++) begin
      fnd_clk = 1'b1;
      model_tick();
      for (int c = 1; c <= 4; c++) begin
        @(posedge clk); #1;
        if (c == 2) fnd_clk = 1'b0;
        if (!(p == 0 && c < 4) && bus.o_fnd_com !== 4'hF) nonf++;
      end
    end
    chk("storm_no_drive", nonf, 0);
    chk("storm_sel", 32'(bus.o_digit_sel), m_sel);
    repeat (8) @(posedge clk);
    #1;
    chk("storm_recover_com", 32'(bus.o_fnd_com), 32'(exp_com(m_sel)));
    chk("storm_recover_font", 32'(bus.o_fnd_font), 32'(exp_font(m_sel, m_bcd, m_dp)));

    // async reset in DRIVE: outputs drop before the next clock edge
    set_in(16'h5A3C, 4'b1010);
    run_period(16);
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_com", 32'(bus.o_fnd_com), 32'hF);
    chk("mid_rst_font", 32'(bus.o_fnd_font), 32'hFF);
    chk("mid_rst_sel", 32'(bus.o_digit_sel), 0);
    chk("mid_rst_frame_done", 32'(bus.o_frame_done), 0);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    m_sel = 0; m_bcd = 16'h0; m_dp = 4'h0;
    repeat (5) @(posedge clk);
    #1;
    chk("post_rst_idle_com", 32'(bus.o_fnd_com), 32'hF);
    repeat (6) run_period(14);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
